// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ctrl_pkg
// Description : Shared definitions for the multicycle main controller:
//               state encoding, opcode constants, ALUOp codes and ALU
//               source-select codes.
// Config      : MAIN_CONTROL_IMM_EN -- when defined, adds the EXECUTE_I
//               state used by I-type ALU instructions (opcode 0010011).
// Revision    : 1.0 -- initial release
// ============================================================================
package ctrl_pkg;

  // Encodings are pinned so state_dbg reads the same with or without the
  // immediate feature; code 8 is simply unused when EXECUTE_I is absent.
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXECUTE_R = 4'd7,
`ifdef MAIN_CONTROL_IMM_EN
    EXECUTE_I = 4'd8,
`endif
    ALU_WB    = 4'd9,
    BRANCH    = 4'd10,
    ILLEGAL   = 4'd11
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic       ALU_SRC_A_PC   = 1'b0;
  localparam logic       ALU_SRC_A_REG  = 1'b1;
  localparam logic [1:0] ALU_SRC_B_REG  = 2'b00;
  localparam logic [1:0] ALU_SRC_B_FOUR = 2'b01;
  localparam logic [1:0] ALU_SRC_B_IMM  = 2'b10;

endpackage : ctrl_pkg
`default_nettype wire

// File: rtl/main_control_opdec.sv
`default_nettype none
// ============================================================================
// Module      : main_control_opdec
// Description : Combinational opcode decoder giving the state that follows
//               DECODE. Unsupported opcodes map to ILLEGAL.
// Ports       : opcode      in  [6:0] instruction register bits [6:0]
//               decode_next out state_t next state out of DECODE
// Config      : MAIN_CONTROL_IMM_EN -- opcode 0010011 maps to EXECUTE_I
//               when defined, otherwise to ILLEGAL.
// Revision    : 1.0 -- initial release
// ============================================================================
module main_control_opdec
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output state_t     decode_next
);

  always_comb begin
    decode_next = ILLEGAL;
    case (opcode)
      OP_LOAD,
      OP_STORE:  decode_next = MEM_ADDR;
      OP_RTYPE:  decode_next = EXECUTE_R;
      OP_BRANCH: decode_next = BRANCH;
`ifdef MAIN_CONTROL_IMM_EN
      OP_IMM:    decode_next = EXECUTE_I;
`endif
      default:   decode_next = ILLEGAL;
    endcase
  end

endmodule : main_control_opdec
`default_nettype wire

// File: rtl/main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : main_control_fsm
// Description : Moore main controller for a multicycle datapath. Sequences
//               fetch, decode, memory, ALU and branch steps and drives the
//               datapath strobes. Only the FETCH write-enables and the
//               MEM_WRITE retire pulse are gated by mem_ready.
// Ports       : clk, rst_n (async, active-low)
//               opcode[6:0]  instruction opcode (sampled in DECODE/MEM_ADDR)
//               zero         ALU zero flag (consumed by the datapath only)
//               mem_ready    memory handshake
//               alu_op[1:0], alu_src_a, alu_src_b[1:0]   ALU controls
//               pc_write, pc_write_cond, pc_source, ir_write, i_or_d,
//               mem_read, mem_write, mem_to_reg, reg_write datapath strobes
//               instr_done   retire pulse; illegal  unsupported-opcode flag
//               state_dbg[3:0] encoded current state
// Config      : MAIN_CONTROL_IMM_EN -- enables the EXECUTE_I path.
// Revision    : 1.0 -- initial release
// ============================================================================
module main_control_fsm
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       pc_source,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state_dbg
);

  state_t state;
  state_t next_state;
  state_t decode_next;

  // The zero flag is ANDed with pc_write_cond in the datapath, not here.
  logic unused_zero;
  assign unused_zero = zero;

  main_control_opdec u_opdec (
    .opcode      (opcode),
    .decode_next (decode_next)
  );

  // Async reset parks the FSM in IDLE; since every output decodes from the
  // state, this also clears all strobes (and illegal) immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state    = state;
    alu_op        = ALUOP_ADD;
    alu_src_a     = ALU_SRC_A_PC;
    alu_src_b     = ALU_SRC_B_REG;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    ir_write      = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state)
      IDLE: begin
        next_state = FETCH;
      end

      FETCH: begin
        // PC+4 is computed every FETCH cycle but only committed (together
        // with the IR load) in the cycle the memory delivers the word.
        mem_read  = 1'b1;
        alu_src_b = ALU_SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) next_state = DECODE;
      end

      DECODE: begin
        // Branch target PC+imm is precomputed into ALUOut here.
        alu_src_b  = ALU_SRC_B_IMM;
        next_state = decode_next;
      end

      MEM_ADDR: begin
        alu_src_a  = ALU_SRC_A_REG;
        alu_src_b  = ALU_SRC_B_IMM;
        next_state = (opcode == OP_STORE) ? MEM_WRITE : MEM_READ;
      end

      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) next_state = MEM_WB;
      end

      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      MEM_WRITE: begin
        // A store retires in the cycle its write is accepted.
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) next_state = FETCH;
      end

      EXECUTE_R: begin
        alu_src_a  = ALU_SRC_A_REG;
        alu_src_b  = ALU_SRC_B_REG;
        alu_op     = ALUOP_FUNC;
        next_state = ALU_WB;
      end

`ifdef MAIN_CONTROL_IMM_EN
      EXECUTE_I: begin
        alu_src_a  = ALU_SRC_A_REG;
        alu_src_b  = ALU_SRC_B_IMM;
        alu_op     = ALUOP_FUNC;
        next_state = ALU_WB;
      end
`endif

      ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        next_state = FETCH;
      end

      BRANCH: begin
        alu_src_a     = ALU_SRC_A_REG;
        alu_src_b     = ALU_SRC_B_REG;
        alu_op        = ALUOP_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        instr_done    = 1'b1;
        next_state    = FETCH;
      end

      ILLEGAL: begin
        // Terminal until reset.
        illegal = 1'b1;
      end

      default: begin
        // Unused encodings fall back to IDLE and restart fetching.
        next_state = IDLE;
      end
    endcase
  end

  assign state_dbg = state;

endmodule : main_control_fsm
`default_nettype wire

// File: tb/tb_main_control_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_control_fsm
// Description : Self-checking bench for main_control_fsm. One table record
//               per clock cycle ({opcode, mem_ready, expected state, expected
//               outputs}), plus hand-written sequences for ILLEGAL stickiness,
//               the 0010011 opcode and reset during a memory wait.
// Config      : honours MAIN_CONTROL_IMM_EN like the design.
// Revision    : 1.0 -- initial release
// ============================================================================
module tb_main_control_fsm;
  import ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write, pc_write_cond, pc_source, ir_write, i_or_d;
  logic       mem_read, mem_write, mem_to_reg, reg_write;
  logic       instr_done, illegal;
  logic [3:0] state_dbg;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  main_control_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .ir_write      (ir_write),
    .i_or_d        (i_or_d),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_to_reg    (mem_to_reg),
    .reg_write     (reg_write),
    .instr_done    (instr_done),
    .illegal       (illegal),
    .state_dbg     (state_dbg)
  );

  // Output bundle: {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond,
  // pc_source, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write,
  // instr_done, illegal}
  logic [15:0] outs;
  assign outs = {alu_op, alu_src_a, alu_src_b, pc_write, pc_write_cond,
                 pc_source, ir_write, i_or_d, mem_read, mem_write,
                 mem_to_reg, reg_write, instr_done, illegal};

  // strb = {pw, pwc, ps, irw, iod, mr, mw, m2r, rw, done, ill}
  function automatic logic [15:0] mk(input logic [1:0] op, input logic sa,
                                     input logic [1:0] sb,
                                     input logic [10:0] strb);
    return {op, sa, sb, strb};
  endfunction

  logic [15:0] o_zero, o_fetch_w, o_fetch_r, o_decode, o_maddr, o_mread;
  logic [15:0] o_mwb, o_mwr_w, o_mwr_r, o_exr, o_exi, o_alwb, o_br, o_ill;

  typedef struct {
    logic [6:0]  opc;
    logic        mr;
    logic [3:0]  st;
    logic [15:0] o;
  } vec_t;

  localparam int NV = 34;
  vec_t tbl [NV];

  task automatic check(input string name, input logic [3:0] est,
                       input logic [15:0] eo);
    checks++;
    if (state_dbg !== est || outs !== eo) begin
      failures++;
      $display("FAIL %s: state=%0d outs=%b, expected state=%0d outs=%b",
               name, state_dbg, outs, est, eo);
    end
  endtask

  // One clock cycle: drive at the negedge, check 1 time unit later, then
  // advance to the next negedge.
  task automatic cyc(input string name, input logic [6:0] opc,
                     input logic mr, input logic [3:0] est,
                     input logic [15:0] eo);
    opcode    = opc;
    mem_ready = mr;
    #1;
    check(name, est, eo);
    @(negedge clk);
  endtask

  function automatic vec_t v(input logic [6:0] opc, input logic mr,
                             input state_t st, input logic [15:0] o);
    vec_t r;
    r.opc = opc; r.mr = mr; r.st = st; r.o = o;
    return r;
  endfunction

  initial begin
    o_zero    = 16'h0000;
    o_fetch_w = mk(2'b00, 1'b0, 2'b01, 11'b000_0_0_1_0_0_0_0_0);
    o_fetch_r = mk(2'b00, 1'b0, 2'b01, 11'b100_1_0_1_0_0_0_0_0);
    o_decode  = mk(2'b00, 1'b0, 2'b10, 11'b000_0_0_0_0_0_0_0_0);
    o_maddr   = mk(2'b00, 1'b1, 2'b10, 11'b000_0_0_0_0_0_0_0_0);
    o_mread   = mk(2'b00, 1'b0, 2'b00, 11'b000_0_1_1_0_0_0_0_0);
    o_mwb     = mk(2'b00, 1'b0, 2'b00, 11'b000_0_0_0_0_1_1_1_0);
    o_mwr_w   = mk(2'b00, 1'b0, 2'b00, 11'b000_0_1_0_1_0_0_0_0);
    o_mwr_r   = mk(2'b00, 1'b0, 2'b00, 11'b000_0_1_0_1_0_0_1_0);
    o_exr     = mk(2'b10, 1'b1, 2'b00, 11'b000_0_0_0_0_0_0_0_0);
    o_exi     = mk(2'b10, 1'b1, 2'b10, 11'b000_0_0_0_0_0_0_0_0);
    o_alwb    = mk(2'b00, 1'b0, 2'b00, 11'b000_0_0_0_0_0_1_1_0);
    o_br      = mk(2'b01, 1'b1, 2'b00, 11'b011_0_0_0_0_0_0_1_0);
    o_ill     = mk(2'b00, 1'b0, 2'b00, 11'b000_0_0_0_0_0_0_0_1);

    // R-type, first cycle after reset release is IDLE
    tbl[0]  = v(7'b0110011, 1'b1, IDLE,      o_zero);
    tbl[1]  = v(7'b0110011, 1'b1, FETCH,     o_fetch_r);
    tbl[2]  = v(7'b0110011, 1'b1, DECODE,    o_decode);
    tbl[3]  = v(7'b0110011, 1'b1, EXECUTE_R, o_exr);
    tbl[4]  = v(7'b0110011, 1'b1, ALU_WB,    o_alwb);
    // load with two wait cycles in MEM_READ (CPI 7)
    tbl[5]  = v(7'b0000011, 1'b1, FETCH,     o_fetch_r);
    tbl[6]  = v(7'b0000011, 1'b1, DECODE,    o_decode);
    tbl[7]  = v(7'b0000011, 1'b1, MEM_ADDR,  o_maddr);
    tbl[8]  = v(7'b0000011, 1'b0, MEM_READ,  o_mread);
    tbl[9]  = v(7'b0000011, 1'b0, MEM_READ,  o_mread);
    tbl[10] = v(7'b0000011, 1'b1, MEM_READ,  o_mread);
    tbl[11] = v(7'b0000011, 1'b1, MEM_WB,    o_mwb);
    // store, no wait
    tbl[12] = v(7'b0100011, 1'b1, FETCH,     o_fetch_r);
    tbl[13] = v(7'b0100011, 1'b1, DECODE,    o_decode);
    tbl[14] = v(7'b0100011, 1'b1, MEM_ADDR,  o_maddr);
    tbl[15] = v(7'b0100011, 1'b1, MEM_WRITE, o_mwr_r);
    // branch
    tbl[16] = v(7'b1100011, 1'b1, FETCH,     o_fetch_r);
    tbl[17] = v(7'b1100011, 1'b1, DECODE,    o_decode);
    tbl[18] = v(7'b1100011, 1'b1, BRANCH,    o_br);
    // R-type with two fetch wait cycles
    tbl[19] = v(7'b0110011, 1'b0, FETCH,     o_fetch_w);
    tbl[20] = v(7'b0110011, 1'b0, FETCH,     o_fetch_w);
    tbl[21] = v(7'b0110011, 1'b1, FETCH,     o_fetch_r);
    tbl[22] = v(7'b0110011, 1'b1, DECODE,    o_decode);
    tbl[23] = v(7'b0110011, 1'b1, EXECUTE_R, o_exr);
    tbl[24] = v(7'b0110011, 1'b1, ALU_WB,    o_alwb);
    // store with one wait cycle
    tbl[25] = v(7'b0100011, 1'b1, FETCH,     o_fetch_r);
    tbl[26] = v(7'b0100011, 1'b1, DECODE,    o_decode);
    tbl[27] = v(7'b0100011, 1'b1, MEM_ADDR,  o_maddr);
    tbl[28] = v(7'b0100011, 1'b0, MEM_WRITE, o_mwr_w);
    tbl[29] = v(7'b0100011, 1'b1, MEM_WRITE, o_mwr_r);
    // unsupported opcode
    tbl[30] = v(7'b1111111, 1'b1, FETCH,     o_fetch_r);
    tbl[31] = v(7'b1111111, 1'b1, DECODE,    o_decode);
    tbl[32] = v(7'b1111111, 1'b1, ILLEGAL,   o_ill);
    tbl[33] = v(7'b1111111, 1'b0, ILLEGAL,   o_ill);

    zero      = 1'b0;
    opcode    = 7'b0110011;
    mem_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_state", IDLE, o_zero);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      cyc($sformatf("vec%0d", i), tbl[i].opc, tbl[i].mr, tbl[i].st, tbl[i].o);
    end

    // ILLEGAL is sticky for 20 more cycles whatever mem_ready does
    for (int i = 0; i < 20; i++) begin
      cyc($sformatf("illegal_hold%0d", i), 7'b0110011, 1'($urandom_range(0, 1)),
          ILLEGAL, o_ill);
    end

    // Reset clears it asynchronously
    #2 rst_n = 1'b0;
    #1;
    check("illegal_reset_clear", IDLE, o_zero);
    @(negedge clk);
    cyc("illegal_reset_held", 7'b0010011, 1'b1, IDLE, o_zero);
    rst_n = 1'b1;

    // Opcode 0010011
    cyc("imm_idle",   7'b0010011, 1'b1, IDLE,   o_zero);
    cyc("imm_fetch",  7'b0010011, 1'b1, FETCH,  o_fetch_r);
    cyc("imm_decode", 7'b0010011, 1'b1, DECODE, o_decode);
`ifdef MAIN_CONTROL_IMM_EN
    cyc("imm_exec",   7'b0010011, 1'b1, EXECUTE_I, o_exi);
    cyc("imm_wb",     7'b0010011, 1'b1, ALU_WB,    o_alwb);
    cyc("imm_next",   7'b0010011, 1'b0, FETCH,     o_fetch_w);
`else
    cyc("imm_illegal0", 7'b0010011, 1'b1, ILLEGAL, o_ill);
    cyc("imm_illegal1", 7'b0110011, 1'b0, ILLEGAL, o_ill);
    cyc("imm_illegal2", 7'b0110011, 1'b1, ILLEGAL, o_ill);
`endif

    // Reset during a FETCH wait
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc("wait_idle",  7'b0110011, 1'b0, IDLE,  o_zero);
    cyc("wait_fetch", 7'b0110011, 1'b0, FETCH, o_fetch_w);
    #2 rst_n = 1'b0;
    #1;
    check("wait_reset_immediate", IDLE, o_zero);
    @(negedge clk);
    cyc("wait_reset_held", 7'b0110011, 1'b1, IDLE, o_zero);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cyc("restart_cycle1", 7'b0110011, 1'b0, IDLE,  o_zero);
    cyc("restart_cycle2", 7'b0110011, 1'b0, FETCH, o_fetch_w);
    cyc("restart_wait",   7'b0110011, 1'b1, FETCH, o_fetch_r);
    cyc("restart_decode", 7'b0110011, 1'b1, DECODE, o_decode);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_main_control_fsm
`default_nettype wire
